// File: rtl/timing_error_monitor.sv
// Timing-error monitor for the FPU pipeline register bank.
// Registers the shadow-compare error flags and keeps one saturating error count
// per monitored register. It also accumulates a windowed aggregate count and
// raises an alarm when that count reaches a threshold. A req/ack port reads,
// and optionally clears, one per-register count.
// Ports:
//   CK, RN             clock, async active-low reset
//   en                 monitoring enable (gates flag capture and window progress)
//   err_flag[NREG]     per-register late-capture flags
//   thresh[CNT_W]      alarm threshold, sampled at window close
//   rd_req/rd_idx/rd_clr  readout request (level), index, clear-on-read
//   rd_ack, rd_data    readout valid and selected count
//   win_count, win_valid, alarm  last completed window total, update pulse, alarm
module timing_error_monitor #(
  parameter int unsigned NREG  = 32,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned WIN_W = 10,
  parameter int unsigned IDX_W = $clog2(NREG)
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             en,
  input  logic [NREG-1:0]  err_flag,
  input  logic [CNT_W-1:0] thresh,
  input  logic             rd_req,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic             rd_clr,
  output logic             rd_ack,
  output logic [CNT_W-1:0] rd_data,
  output logic [CNT_W-1:0] win_count,
  output logic             win_valid,
  output logic             alarm
);

  localparam int unsigned PC_W  = $clog2(NREG + 1);
  localparam int unsigned SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LATCH = 2'd1,
    S_WAIT  = 2'd2
  } rd_state_e;

  logic [NREG-1:0]  flag_q;
  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [WIN_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0] win_acc_q, win_acc_d;
  logic [CNT_W-1:0] win_count_q, win_count_d;
  logic             win_valid_q, win_valid_d;
  logic             alarm_q, alarm_d;
  rd_state_e        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             clr_q, clr_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic             rd_ack_q, rd_ack_d;

  logic             clr_fire_c;
  logic [PC_W-1:0]  pop_c;
  logic [SUM_W-1:0] acc_sum_c;
  logic [CNT_W-1:0] acc_sat_c;

  // Number of registered error events this cycle.
  always_comb begin
    pop_c = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      pop_c = pop_c + PC_W'(flag_q[i]);
    end
  end

  // Saturating window sum including this cycle's events.
  always_comb begin
    acc_sum_c = SUM_W'(win_acc_q) + SUM_W'(pop_c);
    acc_sat_c = (acc_sum_c > SUM_W'(CNT_MAX)) ? CNT_MAX : acc_sum_c[CNT_W-1:0];
  end

  // Window position, accumulator and close-of-window results.
  always_comb begin
    wcnt_d      = wcnt_q;
    win_acc_d   = acc_sat_c;
    win_count_d = win_count_q;
    win_valid_d = 1'b0;
    alarm_d     = alarm_q;
    if (en) begin
      if (wcnt_q == {WIN_W{1'b1}}) begin
        win_count_d = acc_sat_c;
        alarm_d     = (acc_sat_c >= thresh);
        win_valid_d = 1'b1;
        win_acc_d   = '0;
        wcnt_d      = '0;
      end else begin
        wcnt_d = wcnt_q + WIN_W'(1);
      end
    end
  end

  // Readout FSM: next state and registered-output next values.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    clr_d      = clr_q;
    rd_data_d  = rd_data_q;
    rd_ack_d   = rd_ack_q;
    clr_fire_c = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rd_req) begin
          idx_d   = rd_idx;
          clr_d   = rd_clr;
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        rd_data_d  = cnt_q[idx_q];
        rd_ack_d   = 1'b1;
        clr_fire_c = clr_q;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (!rd_req) begin
          rd_ack_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Per-register counters; a clear keeps the event arriving in the clear cycle.
  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr_fire_c && (idx_q == IDX_W'(i))) begin
        cnt_d[i] = CNT_W'(flag_q[i]);
      end else if (flag_q[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      flag_q      <= '0;
      for (int unsigned i = 0; i < NREG; i++) cnt_q[i] <= '0;
      wcnt_q      <= '0;
      win_acc_q   <= '0;
      win_count_q <= '0;
      win_valid_q <= 1'b0;
      alarm_q     <= 1'b0;
      state_q     <= S_IDLE;
      idx_q       <= '0;
      clr_q       <= 1'b0;
      rd_data_q   <= '0;
      rd_ack_q    <= 1'b0;
    end else begin
      flag_q      <= en ? err_flag : '0;
      for (int unsigned i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
      wcnt_q      <= wcnt_d;
      win_acc_q   <= win_acc_d;
      win_count_q <= win_count_d;
      win_valid_q <= win_valid_d;
      alarm_q     <= alarm_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      clr_q       <= clr_d;
      rd_data_q   <= rd_data_d;
      rd_ack_q    <= rd_ack_d;
    end
  end

  assign rd_ack    = rd_ack_q;
  assign rd_data   = rd_data_q;
  assign win_count = win_count_q;
  assign win_valid = win_valid_q;
  assign alarm     = alarm_q;

endmodule

// File: tb/tb_timing_error_monitor.sv
// Self-checking bench for timing_error_monitor: default-size instance checked
// against a cycle-level reference model, plus a narrow instance (4-bit counters,
// 8-cycle window) for saturation and clear-on-read corner cases.
module tb_timing_error_monitor;

  localparam int unsigned NREG = 32;
  localparam int CMAX = 65535;
  localparam int WIN  = 1024;

  logic        CK;
  logic        RN;
  logic        en;
  logic [31:0] err_flag;
  logic [15:0] thresh;
  logic        rd_req;
  logic [4:0]  rd_idx;
  logic        rd_clr;
  logic        rd_ack;
  logic [15:0] rd_data;
  logic [15:0] win_count;
  logic        win_valid;
  logic        alarm;

  logic        s_en;
  logic [3:0]  s_err;
  logic [3:0]  s_thresh;
  logic        s_req;
  logic [1:0]  s_idx;
  logic        s_clr;
  logic        s_ack;
  logic [3:0]  s_data;
  logic [3:0]  s_win_count;
  logic        s_win_valid;
  logic        s_alarm;

  timing_error_monitor u_dut (
    .CK(CK), .RN(RN), .en(en), .err_flag(err_flag), .thresh(thresh),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_clr(rd_clr),
    .rd_ack(rd_ack), .rd_data(rd_data), .win_count(win_count),
    .win_valid(win_valid), .alarm(alarm)
  );

  timing_error_monitor #(.NREG(4), .CNT_W(4), .WIN_W(3)) u_small (
    .CK(CK), .RN(RN), .en(s_en), .err_flag(s_err), .thresh(s_thresh),
    .rd_req(s_req), .rd_idx(s_idx), .rd_clr(s_clr),
    .rd_ack(s_ack), .rd_data(s_data), .win_count(s_win_count),
    .win_valid(s_win_valid), .alarm(s_alarm)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Reference model state (plain integers, cycle-level behaviour)
  int          m_cnt [NREG];
  logic [31:0] m_flag;
  int          m_wpos, m_acc, m_wc;
  bit          m_wv, m_al;
  bit          rnd_mode;
  int          pulses;
  int          n_err, n_chk;

  typedef struct {
    logic [31:0] err;
    int          n;
    int          idx;
    bit          clr;
    int          exp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(NREG); i++) m_cnt[i] = 0;
    m_flag = '0;
    m_wpos = 0;
    m_acc  = 0;
    m_wc   = 0;
    m_wv   = 1'b0;
    m_al   = 1'b0;
  endtask

  // Advance one clock: update model for this edge, then sample after it.
  task automatic step(input bit clr_now = 1'b0, input int clr_idx = 0);
    int pop;
    if (rnd_mode) begin
      en       = ($urandom_range(0, 7) != 0);
      err_flag = $urandom & $urandom & $urandom;
    end
    pop = $countones(m_flag);
    for (int i = 0; i < int'(NREG); i++) begin
      if (clr_now && i == clr_idx) m_cnt[i] = int'(m_flag[i]);
      else                          m_cnt[i] = sat(m_cnt[i] + int'(m_flag[i]));
    end
    m_wv = 1'b0;
    if (en) begin
      if (m_wpos == WIN - 1) begin
        m_wc   = sat(m_acc + pop);
        m_al   = (m_wc >= int'(thresh));
        m_wv   = 1'b1;
        m_acc  = 0;
        m_wpos = 0;
      end else begin
        m_wpos++;
        m_acc = sat(m_acc + pop);
      end
    end else begin
      m_acc = sat(m_acc + pop);
    end
    m_flag = en ? err_flag : 32'h0;
    @(posedge CK);
    #1;
    if (win_valid) pulses++;
    chk("window", 64'({win_valid, win_count, alarm}), 64'({m_wv, 16'(m_wc), m_al}));
  endtask

  task automatic do_read(input int idx, input bit clr, output int got);
    int exp;
    int hold;
    rd_idx = 5'(idx);
    rd_clr = clr;
    rd_req = 1'b1;
    step();
    chk("rd_ack_accept", 64'(rd_ack), 64'(0));
    exp = m_cnt[idx];
    step(clr, idx);
    chk("rd_ack", 64'(rd_ack), 64'(1));
    chk("rd_data", 64'(rd_data), 64'(exp));
    got = int'(rd_data);
    hold = $urandom_range(0, 2);
    repeat (hold) begin
      step();
      chk("rd_hold", 64'({rd_ack, rd_data}), 64'({1'b1, 16'(exp)}));
    end
    rd_req = 1'b0;
    step();
    chk("rd_ack_drop", 64'(rd_ack), 64'(0));
    rd_clr = 1'b0;
  endtask

  task automatic do_reset();
    RN = 1'b0;
    en = 1'b1; err_flag = '0; rd_req = 1'b0; rd_idx = '0; rd_clr = 1'b0;
    s_en = 1'b0; s_err = '0; s_req = 1'b0; s_idx = '0; s_clr = 1'b0;
    repeat (2) @(posedge CK);
    #1;
    chk("reset_out", 64'({rd_ack, rd_data, win_count, win_valid, alarm}), 64'(0));
    chk("s_reset_out", 64'({s_ack, s_data, s_win_count, s_win_valid, s_alarm}), 64'(0));
    RN = 1'b1;
    model_reset();
  endtask

  task automatic wait_pulse(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 2100 && !seen; k++) begin
      step();
      seen = win_valid;
    end
    chk({name, "_seen"}, 64'(seen), 64'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [8];
    int   got;
    bit   seen;

    n_err = 0; n_chk = 0; rnd_mode = 1'b0;
    thresh = 16'd100; s_thresh = 4'd15;

    // Idle after reset: one zero window within 1100 enabled cycles
    do_reset();
    pulses = 0;
    repeat (1100) step();
    chk("idle_pulses", 64'(pulses), 64'(1));
    chk("idle_rd", 64'({rd_ack, rd_data}), 64'(0));

    // Table of count/read vectors from a fresh reset
    tbl[0] = '{32'h0000_0004, 10, 2,  1'b0, 10};
    tbl[1] = '{32'h0000_0000, 1,  3,  1'b0, 0};
    tbl[2] = '{32'h8000_0004, 5,  2,  1'b1, 15};
    tbl[3] = '{32'h8000_0000, 3,  31, 1'b0, 8};
    tbl[4] = '{32'h0000_0000, 1,  2,  1'b0, 0};
    tbl[5] = '{32'hFFFF_FFFF, 2,  0,  1'b1, 2};
    tbl[6] = '{32'h0000_0000, 1,  31, 1'b0, 10};
    tbl[7] = '{32'h0000_0000, 1,  0,  1'b0, 0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      err_flag = tbl[i].err;
      repeat (tbl[i].n) step();
      err_flag = '0;
      do_read(tbl[i].idx, tbl[i].clr, got);
      chk($sformatf("tbl%0d", i), 64'(got), 64'(tbl[i].exp));
    end

    // Window alarm: 30 cycles of four errors each, then an empty window
    wait_pulse("align");
    err_flag = 32'hF;
    repeat (30) step();
    err_flag = '0;
    wait_pulse("w1");
    chk("w1_count", 64'(win_count), 64'(120));
    chk("w1_alarm", 64'(alarm), 64'(1));
    wait_pulse("w2");
    chk("w2_count", 64'(win_count), 64'(0));
    chk("w2_alarm", 64'(alarm), 64'(0));

    // en gating: flags ignored and window frozen
    pulses = 0;
    en = 1'b0;
    err_flag = '1;
    repeat (500) step();
    chk("gate_pulses", 64'(pulses), 64'(0));
    en = 1'b1;
    err_flag = '0;
    do_read(7, 1'b0, got);
    chk("gate_cnt7", 64'(got), 64'(2));
    wait_pulse("gate_resume");

    // Randomized traffic with interleaved reads and clears
    rnd_mode = 1'b1;
    for (int it = 0; it < 120; it++) begin
      thresh = 16'($urandom_range(3000, 5000));
      repeat ($urandom_range(0, 30)) step();
      do_read($urandom_range(0, 31), 1'($urandom_range(0, 1)), got);
    end
    rnd_mode = 1'b0;
    en = 1'b1;
    err_flag = '0;

    // Reset in the middle of a read, then a fresh read with rd_req held
    rd_idx = 5'd5; rd_clr = 1'b0; rd_req = 1'b1;
    step();
    step();
    chk("mr_ack", 64'(rd_ack), 64'(1));
    #3;
    RN = 1'b0;
    #1;
    chk("mr_async", 64'({rd_ack, rd_data, win_count, win_valid, alarm}), 64'(0));
    model_reset();
    @(posedge CK);
    #4;
    RN = 1'b1;
    step();
    chk("mr_accept", 64'(rd_ack), 64'(0));
    step();
    chk("mr_ack2", 64'({rd_ack, rd_data}), 64'({1'b1, 16'd0}));
    rd_req = 1'b0;
    step();
    chk("mr_drop", 64'(rd_ack), 64'(0));

    // Narrow instance: saturation, clear-on-read keeping the clear-cycle event
    s_en = 1'b1; s_err = 4'h1;
    repeat (20) step();
    s_req = 1'b1; s_idx = 2'd0; s_clr = 1'b0;
    step();
    step();
    chk("s_sat", 64'({s_ack, s_data}), 64'({1'b1, 4'd15}));
    s_req = 1'b0;
    step();
    chk("s_drop", 64'(s_ack), 64'(0));
    chk("s_alarm0", 64'(s_alarm), 64'(0));
    s_clr = 1'b1; s_req = 1'b1;
    step();
    step();
    chk("s_clr_read", 64'({s_ack, s_data}), 64'({1'b1, 4'd15}));
    s_req = 1'b0;
    step();
    s_clr = 1'b0; s_req = 1'b1;
    step();
    step();
    chk("s_after_clr", 64'({s_ack, s_data}), 64'({1'b1, 4'd3}));
    s_req = 1'b0;
    step();

    // Narrow instance: window total saturates and meets threshold
    s_err = 4'hF;
    repeat (10) step();
    seen = 1'b0;
    for (int k = 0; k < 16 && !seen; k++) begin
      step();
      seen = s_win_valid;
    end
    chk("s_win_seen", 64'(seen), 64'(1));
    chk("s_win_sat", 64'(s_win_count), 64'(15));
    chk("s_alarm1", 64'(s_alarm), 64'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
